pipeline_fg_fetch: RTL
======================

// Module: pipeline_fg_fetch
// PURPOSE
//   Stage directly upstream of the pixel merger. Takes the timing-aligned background
//   pixel stream and decides whether each pixel lies inside the foreground window.
//   Window position and downscale come from per-frame shadowed controls. For pixels
//   inside the window it issues a fixed-latency read of the foreground framebuffer.
//   It delays background, transparency and window flag so that they emerge aligned
//   with the read data as {use_fg_pixel, bg_pixel, fg_pixel, transparency}.
// PARAMETERS
//   R_WIDTH                 5    red bits per pixel
//   G_WIDTH                 6    green bits per pixel
//   B_WIDTH                 5    blue bits per pixel (PIXEL_SIZE = R+G+B)
//   TRANSPARENCY_PRECISION  3    transparency control width
//   X_WIDTH                 11   screen x coordinate width (unsigned)
//   Y_WIDTH                 10   screen y coordinate width (unsigned)
//   FG_WIDTH                640  foreground buffer width in pixels (row pitch)
//   FG_HEIGHT               480  foreground buffer height in pixels
//   ADDR_WIDTH              19   framebuffer word address width
//   MEM_LATENCY             2    cycles from mem_rd_en/addr edge to valid mem_rd_data (>=1)
// PORTS
//   clk                  in   1            pipeline clock
//   rst_n                in   1            async active-low reset
//   frame_start          in   1            1-cycle pulse before first pixel of a frame
//   pixel_valid_in       in   1            x_in/y_in/bg_pixel_in valid this cycle
//   x_in                 in   X_WIDTH      screen x of current pixel
//   y_in                 in   Y_WIDTH      screen y of current pixel
//   bg_pixel_in          in   PIXEL_SIZE   background pixel
//   ctrl_fg_enable       in   1            foreground overlay on
//   ctrl_fg_scale        in   2            0=1x, 1=1/2, 2=1/4, 3=1x (reserved)
//   ctrl_fg_offset_x     in   X_WIDTH+1    signed screen x of window top-left
//   ctrl_fg_offset_y     in   Y_WIDTH+1    signed screen y of window top-left
//   ctrl_fg_transparency in   TRANSPARENCY_PRECISION  background proportion for merger
//   mem_rd_en            out  1            framebuffer read strobe
//   mem_rd_addr          out  ADDR_WIDTH   framebuffer word address
//   mem_rd_data          in   PIXEL_SIZE   read data, MEM_LATENCY cycles after strobe
//   pixel_valid_out      out  1            aligned outputs valid
//   use_fg_pixel_out     out  1            fg_pixel_out is meaningful; feeds merger
//   bg_pixel_out         out  PIXEL_SIZE   delayed background pixel
//   fg_pixel_out         out  PIXEL_SIZE   foreground pixel (0 when use_fg_pixel_out=0)
//   transparency_out     out  TRANSPARENCY_PRECISION  shadowed transparency, aligned
// BEHAVIOUR
//   Reset: all outputs 0.
//     Shadow ctrl set to enable=0, scale=0, offsets=0, transparency=0.
//     All delay stages cleared; valid bits 0.
//     Reset mid-frame discards in-flight pixels; no reads are issued until the next
//     frame_start loads new shadows.
//   Shadow: on a clk edge with frame_start=1, all ctrl_* are captured.
//     A pixel presented in the same cycle as frame_start uses the old shadow values.
//   Stage A (edge after input):
//     s = scale (3 -> 0); win_w = FG_WIDTH>>s; win_h = FG_HEIGHT>>s.
//     rx = x_in - off_x; ry = y_in - off_y (signed, width+2).
//     inside = valid & enable & 0<=rx<win_w & 0<=ry<win_h.
//     Register mem_rd_en = inside.
//     Register mem_rd_addr = (ry<<s)*FG_WIDTH + (rx<<s) when inside, else hold previous.
//   Window clipping: negative offsets or a window past the screen edge need no special
//     handling; off-screen coordinates never match.
//   Latency: input at cycle N -> read strobe at N+1 -> data valid at N+1+MEM_LATENCY.
//     Outputs are registered at N+2+MEM_LATENCY; fixed latency L = MEM_LATENCY+2.
//   Delay line: valid, inside, bg_pixel and transparency travel L stages alongside.
//     Bubbles (pixel_valid_in=0) propagate as pixel_valid_out=0.
//     During a bubble use_fg_pixel_out=0, bg_pixel_out=0 and fg_pixel_out=0.
//   fg_pixel_out = inside_delayed ? mem_rd_data : 0; use_fg_pixel_out = inside_delayed.
//   No backpressure. One pixel per cycle sustained; no stall input.
// TESTING
//   1. Reset -> all outputs 0; pixels before the first frame_start give mem_rd_en=0
//      and use_fg_pixel_out=0, with bg passed after L=4 cycles (MEM_LATENCY=2).
//   2. frame_start with enable=1, scale=0, off=(100,50); pixel (100,50)
//      -> mem_rd_addr=0 one cycle later.
//      Pixel (739,529) -> addr 307199; pixel (740,50) -> mem_rd_en=0.
//   3. scale=1, off=(0,0), pixel (10,3) -> addr 6*640+20=3860.
//      Pixel (320,0) -> outside.
//      scale=3 behaves exactly as scale=0.
//   4. Change ctrl mid-frame without frame_start -> addresses unchanged.
//      After the next frame_start the new offset applies from the following pixel.
//   5. Memory model returning addr as data -> fg_pixel_out equals the issued address
//      exactly L cycles after input, and bg/transparency stay aligned.
//      Random bubbles are preserved; off_x=-5 gives pixel (0,y) -> rx=5.
//   6. Assert rst_n low mid-line with reads in flight -> outputs 0 immediately
//      (asynchronous).
//      After release, no mem_rd_en until frame_start.

Source files
------------

// File: rtl/pipeline_fg_fetch.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : pipeline_fg_fetch
// Description : Foreground window fetch stage, directly upstream of the pixel
//               merger. For every background pixel it decides whether the
//               pixel falls inside the foreground window. Window position and
//               downscale come from controls that are shadowed once per frame.
//               For pixels inside the window it issues a fixed-latency
//               framebuffer read. Background, transparency and window flag are
//               delayed so that they leave the stage aligned with the read data.
//
// Ports       : clk, rst_n                  clock, async active-low reset
//               frame_start                 1-cycle pulse, loads ctrl shadows
//               pixel_valid_in, x_in, y_in  input pixel qualifier / position
//               bg_pixel_in                 background pixel
//               ctrl_fg_*                   live overlay controls
//               mem_rd_en, mem_rd_addr      framebuffer read request
//               mem_rd_data                 read data, MEM_LATENCY after request
//               pixel_valid_out, use_fg_pixel_out, bg_pixel_out,
//               fg_pixel_out, transparency_out   aligned outputs to merger
//
// Latency     : input at cycle N -> outputs at N + MEM_LATENCY + 2
// Revision    : 1.0  initial release
// ============================================================================
module pipeline_fg_fetch #(
  parameter int R_WIDTH                = 5,
  parameter int G_WIDTH                = 6,
  parameter int B_WIDTH                = 5,
  parameter int TRANSPARENCY_PRECISION = 3,
  parameter int X_WIDTH                = 11,
  parameter int Y_WIDTH                = 10,
  parameter int FG_WIDTH               = 640,
  parameter int FG_HEIGHT              = 480,
  parameter int ADDR_WIDTH             = 19,
  parameter int MEM_LATENCY            = 2,
  localparam int PIXEL_SIZE            = R_WIDTH + G_WIDTH + B_WIDTH
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              frame_start,
  input  logic                              pixel_valid_in,
  input  logic [X_WIDTH-1:0]                x_in,
  input  logic [Y_WIDTH-1:0]                y_in,
  input  logic [PIXEL_SIZE-1:0]             bg_pixel_in,
  input  logic                              ctrl_fg_enable,
  input  logic [1:0]                        ctrl_fg_scale,
  input  logic [X_WIDTH:0]                  ctrl_fg_offset_x,
  input  logic [Y_WIDTH:0]                  ctrl_fg_offset_y,
  input  logic [TRANSPARENCY_PRECISION-1:0] ctrl_fg_transparency,
  output logic                              mem_rd_en,
  output logic [ADDR_WIDTH-1:0]             mem_rd_addr,
  input  logic [PIXEL_SIZE-1:0]             mem_rd_data,
  output logic                              pixel_valid_out,
  output logic                              use_fg_pixel_out,
  output logic [PIXEL_SIZE-1:0]             bg_pixel_out,
  output logic [PIXEL_SIZE-1:0]             fg_pixel_out,
  output logic [TRANSPARENCY_PRECISION-1:0] transparency_out
);

  // Relative coordinates carry one extra bit over the signed offsets so the
  // full range (unsigned screen coord minus signed offset) never wraps.
  localparam int c_rx_w = X_WIDTH + 2;
  localparam int c_ry_w = Y_WIDTH + 2;
  localparam int c_tp_w = TRANSPARENCY_PRECISION;

  // --------------------------------------------------------------------------
  // Per-frame control shadows
  // --------------------------------------------------------------------------
  logic              r_sh_enable;
  logic [1:0]        r_sh_scale;
  logic [X_WIDTH:0]  r_sh_off_x;
  logic [Y_WIDTH:0]  r_sh_off_y;
  logic [c_tp_w-1:0] r_sh_trans;

  // A pixel sampled on the same edge as frame_start still sees the old
  // shadow values, because the shadows only update on that edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_enable <= 1'b0;
      r_sh_scale  <= 2'd0;
      r_sh_off_x  <= '0;
      r_sh_off_y  <= '0;
      r_sh_trans  <= '0;
    end else if (frame_start) begin
      r_sh_enable <= ctrl_fg_enable;
      r_sh_scale  <= ctrl_fg_scale;
      r_sh_off_x  <= ctrl_fg_offset_x;
      r_sh_off_y  <= ctrl_fg_offset_y;
      r_sh_trans  <= ctrl_fg_transparency;
    end
  end

  // --------------------------------------------------------------------------
  // Stage A: window test and address generation (combinational part)
  // --------------------------------------------------------------------------
  logic [1:0]               w_shift;
  logic [c_rx_w-1:0]        w_win_w;
  logic [c_ry_w-1:0]        w_win_h;
  logic signed [c_rx_w-1:0] w_rx;
  logic signed [c_ry_w-1:0] w_ry;
  logic [c_rx_w-1:0]        w_rx_u;
  logic [c_ry_w-1:0]        w_ry_u;
  logic                     w_rx_in;
  logic                     w_ry_in;
  logic                     w_inside;
  logic [ADDR_WIDTH-1:0]    w_rx_a;
  logic [ADDR_WIDTH-1:0]    w_ry_a;
  logic [ADDR_WIDTH-1:0]    w_addr;

  always_comb begin
    // Scale code 3 is reserved and treated as full size.
    w_shift = (r_sh_scale == 2'd3) ? 2'd0 : r_sh_scale;
    w_win_w = c_rx_w'(FG_WIDTH) >> w_shift;
    w_win_h = c_ry_w'(FG_HEIGHT) >> w_shift;

    w_rx = $signed({2'b00, x_in}) - $signed({r_sh_off_x[X_WIDTH], r_sh_off_x});
    w_ry = $signed({2'b00, y_in}) - $signed({r_sh_off_y[Y_WIDTH], r_sh_off_y});
    w_rx_u = $unsigned(w_rx);
    w_ry_u = $unsigned(w_ry);

    // Sign bit clear means rx >= 0; the unsigned compare then covers < win_w.
    // Off-screen window parts need no clipping: no screen coordinate maps there.
    w_rx_in  = !w_rx[c_rx_w-1] && (w_rx_u < w_win_w);
    w_ry_in  = !w_ry[c_ry_w-1] && (w_ry_u < w_win_h);
    w_inside = pixel_valid_in && r_sh_enable && w_rx_in && w_ry_in;

    // Downscaled window samples every 2^s-th buffer pixel in both directions.
    w_rx_a = ADDR_WIDTH'(w_rx_u);
    w_ry_a = ADDR_WIDTH'(w_ry_u);
    w_addr = ((w_ry_a << w_shift) * ADDR_WIDTH'(FG_WIDTH)) + (w_rx_a << w_shift);
  end

  // --------------------------------------------------------------------------
  // Stage A registers: read request plus pixel side-band
  // --------------------------------------------------------------------------
  logic                  r_rd_en;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic                  r_a_valid;
  logic [PIXEL_SIZE-1:0] r_a_bg;
  logic [c_tp_w-1:0]     r_a_trans;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_en   <= 1'b0;
      r_rd_addr <= '0;
      r_a_valid <= 1'b0;
      r_a_bg    <= '0;
      r_a_trans <= '0;
    end else begin
      r_rd_en   <= w_inside;
      // Address holds its last value between reads to avoid needless toggling.
      if (w_inside) begin
        r_rd_addr <= w_addr;
      end
      r_a_valid <= pixel_valid_in;
      r_a_bg    <= bg_pixel_in;
      r_a_trans <= r_sh_trans;
    end
  end

  assign mem_rd_en   = r_rd_en;
  assign mem_rd_addr = r_rd_addr;

  // --------------------------------------------------------------------------
  // Delay line: MEM_LATENCY stages so the last stage lines up with the cycle
  // in which mem_rd_data for the same pixel is valid.
  // --------------------------------------------------------------------------
  logic [MEM_LATENCY-1:0]                 r_d_valid;
  logic [MEM_LATENCY-1:0]                 r_d_inside;
  logic [MEM_LATENCY-1:0][PIXEL_SIZE-1:0] r_d_bg;
  logic [MEM_LATENCY-1:0][c_tp_w-1:0]     r_d_trans;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_d_valid  <= '0;
      r_d_inside <= '0;
      r_d_bg     <= '0;
      r_d_trans  <= '0;
    end else begin
      r_d_valid[0]  <= r_a_valid;
      r_d_inside[0] <= r_rd_en;
      r_d_bg[0]     <= r_a_bg;
      r_d_trans[0]  <= r_a_trans;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        r_d_valid[i]  <= r_d_valid[i-1];
        r_d_inside[i] <= r_d_inside[i-1];
        r_d_bg[i]     <= r_d_bg[i-1];
        r_d_trans[i]  <= r_d_trans[i-1];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output register: capture read data with the aligned side-band. Bubbles
  // present all-zero payload so the merger sees clean data.
  // --------------------------------------------------------------------------
  logic                  w_last_valid;
  logic                  w_last_inside;
  logic                  r_valid_out;
  logic                  r_use_fg;
  logic [PIXEL_SIZE-1:0] r_bg_out;
  logic [PIXEL_SIZE-1:0] r_fg_out;
  logic [c_tp_w-1:0]     r_trans_out;

  assign w_last_valid  = r_d_valid[MEM_LATENCY-1];
  assign w_last_inside = r_d_inside[MEM_LATENCY-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid_out <= 1'b0;
      r_use_fg    <= 1'b0;
      r_bg_out    <= '0;
      r_fg_out    <= '0;
      r_trans_out <= '0;
    end else begin
      r_valid_out <= w_last_valid;
      r_use_fg    <= w_last_inside;
      r_bg_out    <= w_last_valid  ? r_d_bg[MEM_LATENCY-1]    : '0;
      r_fg_out    <= w_last_inside ? mem_rd_data              : '0;
      r_trans_out <= w_last_valid  ? r_d_trans[MEM_LATENCY-1] : '0;
    end
  end

  assign pixel_valid_out  = r_valid_out;
  assign use_fg_pixel_out = r_use_fg;
  assign bg_pixel_out     = r_bg_out;
  assign fg_pixel_out     = r_fg_out;
  assign transparency_out = r_trans_out;

endmodule
`default_nettype wire
